// File: rtl/serial_word_packer_if.sv
// rtl/serial_word_packer_if.sv - serial input, FIFO write port and status bundle for serial_word_packer
//
// Signals:
//   ser_valid, ser_bit, ser_sof  serial frame input (MSB first, sof marks the first bit)
//   fifo_full                    downstream FIFO full flag
//   data_1, data_1_en            FIFO write data and one-cycle write strobe
//   frame_err                    one-cycle pulse on an aborted frame
//   overflow_cnt                 saturating count of dropped words
//   busy                         frame in progress or words waiting
// Modports: slave = packer side, master = stimulus / upstream side.

interface serial_word_packer_if #(
    parameter int DATA_W = 16
);
    logic              ser_valid;
    logic              ser_bit;
    logic              ser_sof;
    logic              fifo_full;
    logic [DATA_W-1:0] data_1;
    logic              data_1_en;
    logic              frame_err;
    logic [7:0]        overflow_cnt;
    logic              busy;

    modport slave (
        input  ser_valid, ser_bit, ser_sof, fifo_full,
        output data_1, data_1_en, frame_err, overflow_cnt, busy
    );

    modport master (
        output ser_valid, ser_bit, ser_sof, fifo_full,
        input  data_1, data_1_en, frame_err, overflow_cnt, busy
    );
endinterface

// File: rtl/serial_word_packer.sv
// rtl/serial_word_packer.sv - frames an MSB-first serial stream into words and feeds the FIFO write port
//
// Ports:
//   clk_1  in  write-domain clock, posedge
//   rst    in  asynchronous active-high reset
//   bus    serial_word_packer_if.slave (serial input, fifo_full in; data_1/data_1_en,
//          frame_err, overflow_cnt, busy out, all registered)

module serial_word_packer #(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk_1,
    input  logic                 rst,
    serial_word_packer_if.slave  bus
);
    localparam int CNT_W  = $clog2(DATA_W + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    bit_cnt, bit_cnt_n;
    logic [DATA_W-1:0]   shift_reg, shift_n;
    logic [IDLE_W-1:0]   idle_cnt, idle_n;
    logic                push;
    logic [DATA_W-1:0]   push_word;
    logic                err_n;

    // Two-entry hold queue; q0 is always the head.
    logic [DATA_W-1:0]   q0, q1, q0_n, q1_n;
    logic [1:0]          q_cnt, q_cnt_n;
    logic                pop, accept, drop;

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift_reg;
        idle_n    = idle_cnt;
        push      = 1'b0;
        push_word = '0;
        err_n     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.ser_valid && bus.ser_sof) begin
                    shift_n   = {{(DATA_W-1){1'b0}}, bus.ser_bit};
                    bit_cnt_n = CNT_W'(1);
                    idle_n    = '0;
                    state_n   = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.ser_valid) begin
                    idle_n = '0;
                    if (bus.ser_sof) begin
                        // Early SOF: drop the partial word, the SOF bit opens a new frame.
                        err_n     = 1'b1;
                        shift_n   = {{(DATA_W-1){1'b0}}, bus.ser_bit};
                        bit_cnt_n = CNT_W'(1);
                    end else begin
                        shift_n = {shift_reg[DATA_W-2:0], bus.ser_bit};
                        if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                            push      = 1'b1;
                            push_word = {shift_reg[DATA_W-2:0], bus.ser_bit};
                            bit_cnt_n = '0;
                            state_n   = IDLE;
                        end else begin
                            bit_cnt_n = bit_cnt + CNT_W'(1);
                        end
                    end
                end else if (idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th consecutive idle cycle: abort the frame.
                    err_n     = 1'b1;
                    shift_n   = '0;
                    bit_cnt_n = '0;
                    idle_n    = '0;
                    state_n   = IDLE;
                end else begin
                    idle_n = idle_cnt + IDLE_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Pop decision uses the registered occupancy, so a word pushed at edge k
    // is written at edge k+1 at the earliest.
    always_comb begin
        pop     = (q_cnt != 2'd0) && !bus.fifo_full;
        accept  = push && ((q_cnt != 2'd2) || pop);
        drop    = push && !accept;
        q0_n    = q0;
        q1_n    = q1;
        q_cnt_n = q_cnt;
        if (pop) begin
            q0_n    = q1;
            q_cnt_n = q_cnt - 2'd1;
        end
        if (accept) begin
            if (q_cnt_n == 2'd0) begin
                q0_n = push_word;
            end else begin
                q1_n = push_word;
            end
            q_cnt_n = q_cnt_n + 2'd1;
        end
    end

    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            idle_cnt  <= '0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shift_reg <= shift_n;
            idle_cnt  <= idle_n;
        end
    end

    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
            q0               <= '0;
            q1               <= '0;
            q_cnt            <= 2'd0;
            bus.data_1       <= '0;
            bus.data_1_en    <= 1'b0;
            bus.frame_err    <= 1'b0;
            bus.overflow_cnt <= 8'd0;
            bus.busy         <= 1'b0;
        end else begin
            q0            <= q0_n;
            q1            <= q1_n;
            q_cnt         <= q_cnt_n;
            bus.data_1_en <= pop;
            if (pop) begin
                bus.data_1 <= q0;
            end
            bus.frame_err <= err_n;
            if (drop && (bus.overflow_cnt != 8'hFF)) begin
                bus.overflow_cnt <= bus.overflow_cnt + 8'd1;
            end
            bus.busy <= (state_n == SHIFT) || (q_cnt_n != 2'd0);
        end
    end
endmodule

// File: tb/tb_serial_word_packer.sv
// tb/tb_serial_word_packer.sv - directed, table-driven bench for serial_word_packer

module tb_serial_word_packer;
    logic clk_1 = 1'b0;
    logic rst   = 1'b1;

    always #5 clk_1 = ~clk_1;

    serial_word_packer_if #(.DATA_W(16)) bus ();

    serial_word_packer #(.DATA_W(16), .TIMEOUT(64)) dut (
        .clk_1 (clk_1),
        .rst   (rst),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int err_cnt = 0;
    logic [15:0] wr_q[$];
    int          wr_cyc[$];

    always @(posedge clk_1) cyc = cyc + 1;

    always @(negedge clk_1) begin
        if (bus.data_1_en) begin
            wr_q.push_back(bus.data_1);
            wr_cyc.push_back(cyc);
        end
        if (bus.frame_err) err_cnt = err_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        wr_q.delete();
        wr_cyc.delete();
        err_cnt = 0;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_1);
            #1;
        end
    endtask

    task automatic drive_bit(input logic sof, input logic b);
        bus.ser_valid = 1'b1;
        bus.ser_sof   = sof;
        bus.ser_bit   = b;
        tick(1);
    endtask

    task automatic idle_line();
        bus.ser_valid = 1'b0;
        bus.ser_sof   = 1'b0;
        bus.ser_bit   = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) drive_bit(i == 15, w[i]);
        idle_line();
    endtask

    task automatic send_partial(input int n);
        for (int i = 0; i < n; i++) drive_bit(i == 0, 1'b1);
    endtask

    typedef struct {
        logic [15:0] word;
        int          prefix;
        int          exp_err;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int last_edge;
        vecs[0] = '{16'hA5C3, 0,  0, 16'hA5C3};
        vecs[1] = '{16'h1234, 7,  1, 16'h1234};
        vecs[2] = '{16'h0000, 0,  0, 16'h0000};
        vecs[3] = '{16'hFFFF, 0,  0, 16'hFFFF};
        vecs[4] = '{16'h8001, 15, 1, 16'h8001};
        vecs[5] = '{16'h5A5A, 1,  1, 16'h5A5A};

        idle_line();
        bus.fifo_full = 1'b0;
        #1;
        check("reset data_1",       32'(bus.data_1), 32'h0);
        check("reset data_1_en",    32'(bus.data_1_en), 32'h0);
        check("reset frame_err",    32'(bus.frame_err), 32'h0);
        check("reset overflow_cnt", 32'(bus.overflow_cnt), 32'h0);
        check("reset busy",         32'(bus.busy), 32'h0);
        tick(2);
        rst = 1'b0;
        tick(2);

        for (int v = 0; v < 6; v++) begin
            clear_mon();
            if (vecs[v].prefix > 0) send_partial(vecs[v].prefix);
            send_frame(vecs[v].word);
            last_edge = cyc;
            tick(5);
            check($sformatf("vec%0d write count", v), 32'(wr_q.size()), 32'd1);
            if (wr_q.size() > 0) begin
                check($sformatf("vec%0d data", v), 32'(wr_q[0]), 32'(vecs[v].exp_data));
                check($sformatf("vec%0d latency", v), 32'(wr_cyc[0]), 32'(last_edge + 1));
            end
            check($sformatf("vec%0d frame_err", v), 32'(err_cnt), 32'(vecs[v].exp_err));
            check($sformatf("vec%0d busy after", v), 32'(bus.busy), 32'h0);
        end

        // Queue full with the FIFO blocked: third word is dropped.
        clear_mon();
        bus.fifo_full = 1'b1;
        send_frame(16'h0001);
        send_frame(16'h0002);
        send_frame(16'h0003);
        tick(3);
        check("ovf cnt after 3", 32'(bus.overflow_cnt), 32'd1);
        check("ovf no writes", 32'(wr_q.size()), 32'd0);
        check("ovf busy", 32'(bus.busy), 32'd1);
        bus.fifo_full = 1'b0;
        tick(5);
        check("ovf drain count", 32'(wr_q.size()), 32'd2);
        if (wr_q.size() == 2) begin
            check("ovf drain first", 32'(wr_q[0]), 32'h0001);
            check("ovf drain second", 32'(wr_q[1]), 32'h0002);
            check("ovf back to back", 32'(wr_cyc[1]), 32'(wr_cyc[0] + 1));
        end

        // Timeout: 63 idle cycles keep the frame alive, the 64th aborts it.
        clear_mon();
        send_partial(5);
        idle_line();
        tick(63);
        check("timeout no err at 63", 32'(bus.frame_err), 32'd0);
        check("timeout busy at 63", 32'(bus.busy), 32'd1);
        tick(1);
        check("timeout err at 64", 32'(bus.frame_err), 32'd1);
        check("timeout busy cleared", 32'(bus.busy), 32'd0);
        tick(3);
        check("timeout err single", 32'(err_cnt), 32'd1);
        check("timeout no write", 32'(wr_q.size()), 32'd0);

        // Reset mid-frame with a word queued behind a full FIFO.
        clear_mon();
        bus.fifo_full = 1'b1;
        send_frame(16'h7777);
        send_partial(4);
        rst = 1'b1;
        #1;
        check("rst data_1",       32'(bus.data_1), 32'h0);
        check("rst data_1_en",    32'(bus.data_1_en), 32'h0);
        check("rst overflow_cnt", 32'(bus.overflow_cnt), 32'h0);
        check("rst busy",         32'(bus.busy), 32'h0);
        idle_line();
        tick(2);
        rst = 1'b0;
        bus.fifo_full = 1'b0;
        tick(10);
        check("rst queue discarded", 32'(wr_q.size()), 32'd0);
        send_frame(16'hBEEF);
        tick(4);
        check("rst new frame count", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() > 0) check("rst new frame data", 32'(wr_q[0]), 32'hBEEF);

        // Saturation: 300 frames against a full FIFO.
        clear_mon();
        bus.fifo_full = 1'b1;
        for (int f = 0; f < 300; f++) begin
            send_frame(16'(f + 16'h0100));
            if (f == 255) check("sat at 256 frames", 32'(bus.overflow_cnt), 32'd254);
            if (f == 256) check("sat at 257 frames", 32'(bus.overflow_cnt), 32'd255);
        end
        check("sat at 300 frames", 32'(bus.overflow_cnt), 32'd255);
        check("sat no writes", 32'(wr_q.size()), 32'd0);
        bus.fifo_full = 1'b0;
        tick(5);
        check("sat drain count", 32'(wr_q.size()), 32'd2);
        if (wr_q.size() == 2) begin
            check("sat drain first", 32'(wr_q[0]), 32'h0100);
            check("sat drain second", 32'(wr_q[1]), 32'h0101);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
